// File: rtl/cla_share_arbiter_pkg.sv
// Shared definitions for the shared carry-lookahead adder arbiter.
//   - default widths and requester count
//   - clog2 helper used to size the requester ID
//   - response record {sum, cout, ovf, id} at the default sizes
package cla_share_arbiter_pkg;

    localparam int unsigned DefWidth  = 16;
    localparam int unsigned DefNumReq = 4;

    // Ceiling log2, usable in parameter defaults.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DefIdW = clog2(DefNumReq);

    // Response record at the default configuration. Consumers outside the
    // block can use it to unpack {rsp_sum, rsp_cout, rsp_ovf, rsp_id}.
    typedef struct packed {
        logic [DefWidth-1:0] sum;
        logic                cout;
        logic                ovf;
        logic [DefIdW-1:0]   id;
    } rsp_rec_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Combinational carry-lookahead adder.
// Ports:
//   a, b  : WIDTH-bit operands
//   cin   : carry-in
//   sum   : WIDTH-bit sum
//   cout  : carry-out
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    // Each carry is expanded directly from generate/propagate terms and cin,
    // so no carry depends on a lower carry.
    always_comb begin
        logic term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        term = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = c[i+1] | term;
        end
        sum  = p ^ c[WIDTH-1:0];
        cout = c[WIDTH];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above ptr,
// wrapping modulo NUM_REQ. Purely combinational.
// Ports:
//   valid  : per-requester request
//   ptr    : highest-priority index
//   enable : when low, no grant is issued
//   grant  : one-hot grant (or zero)
//   idx    : encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        logic            found;
        int unsigned     cand;
        logic [ID_W-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand     = (32'(ptr) + off) % NUM_REQ;
            cand_idx = cand[ID_W-1:0];
            if (enable && !found && valid[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one carry-lookahead adder between NUM_REQ requesters. A round-robin
// arbiter accepts at most one request per cycle; the sum is captured in a
// single registered response slot returned with the requester ID.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_ready: per-requester handshake (ready is one-hot or zero)
//   req_a, req_b       : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin            : per-requester carry-in
//   rsp_valid/rsp_ready: response handshake
//   rsp_sum, rsp_cout  : registered sum and carry-out
//   rsp_ovf            : registered signed overflow
//   rsp_id             : requester that produced the response
//   grant_cnt          : saturating count of accepted requests
module cla_share_arbiter
    import cla_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic [ID_W-1:0]          rsp_id,
    output logic [15:0]              grant_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic [ID_W-1:0]  id;
    } rsp_t;

    rsp_t              rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [15:0]       grant_cnt_q, grant_cnt_d;

    logic              slot_free;
    logic              arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];
    logic [WIDTH-1:0]  op_a, op_b;
    logic              op_cin;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    // The slot can take a new result if empty or being drained this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;
    // rst_n gates the grant so req_ready stays low throughout reset.
    assign arb_en    = slot_free && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;
    // The grant only ever selects a valid requester, so any grant is a transfer.
    assign accept    = |grant;

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    assign op_a   = a_arr[grant_idx];
    assign op_b   = b_arr[grant_idx];
    assign op_cin = req_cin[grant_idx];

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        ptr_d       = ptr_q;
        grant_cnt_d = grant_cnt_q;
        if (accept) begin
            rsp_d.sum   = add_sum;
            rsp_d.cout  = add_cout;
            rsp_d.ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            rsp_d.id    = grant_idx;
            rsp_valid_d = 1'b1;
            if (32'(grant_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
            if (grant_cnt_q != 16'hFFFF) begin
                grant_cnt_d = grant_cnt_q + 16'd1;
            end
        end else if (rsp_ready) begin
            // Drained with nothing behind it: data registers keep their values.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            ptr_q       <= '0;
            grant_cnt_q <= '0;
        end else begin
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            ptr_q       <= ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_cout  = rsp_q.cout;
    assign rsp_ovf   = rsp_q.ovf;
    assign rsp_id    = rsp_q.id;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_cla_share_arbiter.sv
module tb_cla_share_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;
    logic [1:0]     rsp_id;
    logic [15:0]    grant_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Default operands per requester and their hand-computed sums (cin=0).
    logic [15:0] def_a   [N] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] def_b   [N] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] def_sum [N] = '{16'h1112, 16'h2224, 16'h3336, 16'h4448};

    cla_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
    endtask

    task automatic load_defaults();
        for (int i = 0; i < N; i++) set_op(i, def_a[i], def_b[i], 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1111;
        req_a = '0; req_b = '0; req_cin = '0;
        load_defaults();
        #2;
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ready: got %b exp 0000", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        step();
        n_chk++; if (rsp_valid !== 1'b0 || grant_cnt !== 16'd0 || rsp_sum !== 16'h0) begin
            n_fail++; $display("FAIL reset_hold: valid %b cnt %h sum %h exp 0 0 0",
                               rsp_valid, grant_cnt, rsp_sum); end
        #2 rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h1112) begin
            n_fail++; $display("FAIL reset_first_rsp: valid %b id %0d sum %h exp 1 0 1112",
                               rsp_valid, rsp_id, rsp_sum); end
        n_chk++; if (grant_cnt !== 16'd1) begin n_fail++;
            $display("FAIL reset_cnt: got %0d exp 1", grant_cnt); end
        step();
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL drain_empty: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_single();
        set_op(2, 16'h1234, 16'h4321, 1'b0);
        req_valid = 4'b0100;
        #1;
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++;
            $display("FAIL single_ready: got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_fail++;
            $display("FAIL single_id: valid %b id %0d exp 1 2", rsp_valid, rsp_id); end
        n_chk++; if (rsp_sum !== 16'h5555 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
            n_fail++; $display("FAIL single_sum: sum %h cout %b ovf %b exp 5555 0 0",
                               rsp_sum, rsp_cout, rsp_ovf); end
        step();
        n_chk++; if (rsp_valid !== 1'b0 || rsp_sum !== 16'h5555) begin n_fail++;
            $display("FAIL single_drain: valid %b sum %h exp 0 5555", rsp_valid, rsp_sum); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        load_defaults();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== def_sum[k % 4]) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: valid %b id %0d sum %h exp 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_sum, k % 4, def_sum[k % 4]);
            end
        end
        req_valid = '0;
        n_chk++; if (grant_cnt !== 16'd8) begin n_fail++;
            $display("FAIL rr_cnt: got %0d exp 8", grant_cnt); end
        step();
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1111;
        step();
        rsp_ready = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL bp_ready: got %b exp 0000", req_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h1112 ||
                rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid %b id %0d sum %h cout %b ready %b exp 1 0 1112 0 0000",
                         k, rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL bp_release_ready: got %b exp 0010", req_ready); end
        step();
        req_valid = '0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 16'h2224) begin
            n_fail++; $display("FAIL bp_no_bubble: valid %b id %0d sum %h exp 1 1 2224",
                               rsp_valid, rsp_id, rsp_sum); end
        n_chk++; if (grant_cnt !== 16'd10) begin n_fail++;
            $display("FAIL bp_cnt: got %0d exp 10", grant_cnt); end
        step();
    endtask

    task automatic test_boundaries();
        int          r   [4] = '{1, 2, 3, 0};
        logic [15:0] va  [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] vb  [4] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
        logic        vc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] es  [4] = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFF};
        logic        eco [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        eov [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  oh;
        for (int v = 0; v < 4; v++) begin
            set_op(r[v], va[v], vb[v], vc[v]);
            oh = 4'b0001 << r[v];
            req_valid = oh;
            #1;
            n_chk++; if (req_ready !== oh) begin n_fail++;
                $display("FAIL bnd%0d_ready: got %b exp %b", v, req_ready, oh); end
            step();
            req_valid = '0;
            n_chk++;
            if (rsp_sum !== es[v] || rsp_cout !== eco[v] || rsp_ovf !== eov[v] ||
                rsp_id !== 2'(r[v])) begin
                n_fail++;
                $display("FAIL bnd%0d_rsp: sum %h cout %b ovf %b id %0d exp %h %b %b %0d",
                         v, rsp_sum, rsp_cout, rsp_ovf, rsp_id, es[v], eco[v], eov[v], r[v]);
            end
        end
    endtask

    task automatic test_idle_ptr();
        // Last grant was requester 0, so ptr is 1 and must survive idle cycles.
        for (int k = 0; k < 3; k++) step();
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL idle_valid: got %b exp 0", rsp_valid); end
        req_valid = 4'b1111;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL idle_ptr_ready: got %b exp 0010", req_ready); end
        step();
        req_valid = '0;
        n_chk++; if (rsp_id !== 2'd1 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1) begin
            n_fail++; $display("FAIL idle_ptr_rsp: id %0d sum %h cout %b exp 1 0000 1",
                               rsp_id, rsp_sum, rsp_cout); end
        step();
    endtask

    task automatic test_async_reset();
        load_defaults();
        req_valid = 4'b0100;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 16'h3336) begin
            n_fail++; $display("FAIL areset_pre: valid %b id %0d sum %h exp 1 2 3336",
                               rsp_valid, rsp_id, rsp_sum); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_id !== 2'd0 || rsp_cout !== 1'b0 ||
            rsp_ovf !== 1'b0 || grant_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_clear: valid %b sum %h id %0d cout %b ovf %b cnt %0d exp all 0",
                     rsp_valid, rsp_sum, rsp_id, rsp_cout, rsp_ovf, grant_cnt);
        end
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++;
            $display("FAIL areset_ready: got %b exp 0000", req_ready); end
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL areset_ptr: got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h1112 ||
                     grant_cnt !== 16'd1) begin
            n_fail++; $display("FAIL areset_first: valid %b id %0d sum %h cnt %0d exp 1 0 1112 1",
                               rsp_valid, rsp_id, rsp_sum, grant_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundaries();
        test_idle_ptr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_share_arbiter.md
Name: cla_share_arbiter

Overview:
Shares one combinational carry_lookahead_adder between NUM_REQ independent requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the adder result is captured in a single registered response slot. The response returns with the requester ID, under backpressure from the consumer. The block sits between the per-lane operand sources and the shared arithmetic resource.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; equals clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as req_a
- req_cin  in  NUM_REQ  per-requester carry-in
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_sum  out  WIDTH  registered sum
- rsp_cout  out  1  registered carry-out
- rsp_ovf  out  1  registered signed overflow flag
- rsp_id  out  ID_W  index of the requester that produced this result
- grant_cnt  out  16  saturating count of accepted requests (debug)

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id to 0;
  - grant_cnt to 0;
  - the round-robin pointer to 0;
  - req_ready to 0 while rst_n is low.
- Slot free condition: slot_free = !rsp_valid || rsp_ready. When slot_free is 0, every req_ready bit is 0.
- Arbitration:
  - When slot_free is 1, grant the first requester with req_valid=1, searching from ptr upward modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only. The grant is combinational from req_valid, ptr and slot_free.
- Transfer: a request is accepted when req_valid[i] && req_ready[i] at a rising edge. On acceptance:
  - rsp_sum and rsp_cout are loaded from the shared adder driven by the granted operands;
  - rsp_ovf is loaded as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]);
  - rsp_id is loaded with g and rsp_valid is set to 1;
  - ptr is set to (g+1) mod NUM_REQ;
  - grant_cnt increments, saturating at 16'hFFFF.
- Latency: 1 cycle from acceptance to rsp_valid=1. Throughput is 1 result per cycle while rsp_ready stays high.
- No request accepted: if rsp_ready=1 and no request is accepted, rsp_valid clears to 0 and the data registers hold their values. If rsp_ready=0, the slot holds all of its values.
- Simultaneous drain and fill: a response handshake and a new acceptance in the same cycle replace the slot with no bubble.
- Stable response: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs are stable.
- Held requests: a requester holds its valid and operands until its req_ready is seen; the block does not require this, but only sampled operands matter.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,2,3,0,... A requester waits at most NUM_REQ-1 accepted grants.
- Wrap-around:
  - 16'hFFFF + 16'h0000 with cin=1 gives sum 0, cout 1, ovf 0;
  - 16'h7FFF + 16'h0001 gives sum 16'h8000, cout 0, ovf 1.
- ptr only advances on acceptance; idle cycles do not move it.
- Reset asserted mid-transfer drops any held response; no partial state survives.

Decomposition:
- Shared package: ID_W derivation (clog2 function), the default NUM_REQ/WIDTH constants, and a response-record struct {sum, cout, ovf, id}.
- Sub-module rr_arbiter (NUM_REQ): inputs are valid, ptr and enable; outputs are a one-hot grant and the encoded index. This is the natural split.
- The adder is an instance of the existing carry_lookahead_adder with WIDTH passed through. Operand selection is a mux indexed by the encoded grant.

Test Plan:
1. Reset held with all valids=1 -> req_ready=0, rsp_valid=0. After release, first grant goes to requester 0 and rsp_id=0 one cycle later.
2. Requester 2 only, a=16'h1234, b=16'h4321, cin=0 -> rsp_sum=16'h5555, cout=0, ovf=0, rsp_id=2 one cycle after acceptance.
3. All four valid, rsp_ready=1, for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, rsp_valid=1 every cycle, grant_cnt=8.
4. Backpressure: rsp_ready=0 for 3 cycles with a full slot -> req_ready all 0 and rsp_* stable. Releasing rsp_ready gives the next grant the same cycle, with no bubble.
5. Boundaries:
   - a=16'hFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0;
   - a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, cout=0, ovf=1;
   - a=16'h8000, b=16'h8000, cin=0 -> sum=0, cout=1, ovf=1.
6. Async reset pulsed mid-stream while rsp_valid=1 -> outputs are 0 immediately without a clock edge. ptr=0 after release, so requester 0 is granted first.
